score_tick_generator: RTL

//  Producer side of the score-counter interface: generates the score increment clock
//  and the score clear pulse consumed by the 4-digit BCD score display.

---
 rtl/score_tick_generator.sv | 69 ++++++
 1 files changed

// File: rtl/score_tick_generator.sv
// score_tick_generator: game FSM plus accelerating score tick divider feeding the BCD score display
module score_tick_generator #(
  parameter int unsigned DIV_INIT    = 2_500_000,
  parameter int unsigned DIV_MIN     = 1_000_000,
  parameter int unsigned DIV_STEP    = 250_000,
  parameter int unsigned STEP_POINTS = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        collide,
  output logic        ScoreClock,
  output logic        score_rst,
  output logic        running,
  output logic        game_over,
  output logic [3:0]  speed_level,
  output logic [13:0] points
);
  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;
  state_t state;
  logic [31:0] div_cnt, cur_div, step_cnt, next_div;
  logic tc;
  assign tc = div_cnt == cur_div - 32'd1;
  // Floor at DIV_MIN by comparing the headroom first, so the subtract never wraps
  assign next_div = (cur_div - DIV_MIN >= DIV_STEP) ? cur_div - DIV_STEP : DIV_MIN;
  assign running = state == RUN;
  assign game_over = state == OVER;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ScoreClock <= 1'b0;
      score_rst <= 1'b0;
      speed_level <= 4'd0;
      points <= 14'd0;
      div_cnt <= 32'd0;
      cur_div <= DIV_INIT;
      step_cnt <= 32'd0;
    end else begin
      ScoreClock <= 1'b0;
      score_rst <= 1'b0;
      if (state != RUN) begin
        if (start) begin
          state <= RUN;
          score_rst <= 1'b1;
          div_cnt <= 32'd0;
          points <= 14'd0;
          step_cnt <= 32'd0;
          speed_level <= 4'd0;
          cur_div <= DIV_INIT;
        end
      end else if (collide) begin
        state <= OVER;
      end else if (tc) begin
        div_cnt <= 32'd0;
        ScoreClock <= 1'b1;
        points <= (points == 14'd9999) ? 14'd0 : points + 14'd1;
        if (step_cnt == STEP_POINTS - 1) begin
          step_cnt <= 32'd0;
          cur_div <= next_div;
          speed_level <= (speed_level == 4'd15) ? 4'd15 : speed_level + 4'd1;
        end else begin
          step_cnt <= step_cnt + 32'd1;
        end
      end else begin
        div_cnt <= div_cnt + 32'd1;
      end
    end
  end
endmodule
